seq_restoring_divider_16bit: RTL and testbench
==============================================

// Module: seq_restoring_divider_16bit
// PURPOSE
//  - Multi-cycle unsigned restoring divider: the subtract-and-shift inverse of the CLA adder path.
//  - Computes quotient/remainder of dividend/divisor, one quotient bit per clock.
//  - Trial subtraction is a + ~b + 1; the carry-out (no borrow) selects restore vs. accept.
//  - Sits beside the adder datapath as the ALU's divide unit, using a start/done handshake.
// PARAMETERS
//  - WIDTH  16  operand, quotient and remainder width in bits
// PORTS
//  - clk           in   1      single clock; all state updates on posedge
//  - rst           in   1      asynchronous, active-high reset
//  - start         in   1      request; sampled only when busy==0
//  - dividend      in   WIDTH  numerator; captured on an accepted start
//  - divisor       in   WIDTH  denominator; captured on an accepted start
//  - busy          out  1      high while in RUN
//  - done          out  1      one-cycle pulse; results valid from this cycle onward
//  - quotient      out  WIDTH  result; held until the next accepted start
//  - remainder     out  WIDTH  result; held until the next accepted start
//  - div_by_zero   out  1      set with done when the captured divisor==0; held with results
// BEHAVIOUR
//  - Reset: FSM=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, step counter=0.
//    Applies asynchronously at any time, including mid-RUN; the partial result is discarded.
//  - FSM states and transitions:
//    - IDLE: start=1 captures the operands, clears div_by_zero, then goes to
//      DONE if divisor==0, otherwise RUN.
//    - RUN: exactly WIDTH iterations, then DONE.
//    - DONE: done=1 for exactly one cycle. start=1 here is accepted as in IDLE (back-to-back ops);
//      otherwise the FSM goes to IDLE.
//  - start while busy==1 is ignored; captured operands and progress are unaffected.
//  - RUN iteration:
//    - Form {R,Q} <= {R,Q} << 1, with Q preloaded with the dividend and R=0 at start.
//    - D = {1'b0,R_shifted} + {1'b0,~divisor} + 1, computed WIDTH+1 wide.
//    - If the carry/D[WIDTH] shows no borrow: R <= D[WIDTH-1:0] and Q[0] <= 1. Otherwise keep R_shifted and set Q[0] <= 0.
//    - R must be WIDTH+1 bits internally so that divisor >= 2^(WIDTH-1) works.
//  - Latency: start sampled at edge k; busy=1 for cycles k+1..k+WIDTH; done=1 in cycle k+WIDTH+1 (17 cycles at default).
//  - Divide by zero: done in cycle k+1 with quotient = all ones, remainder = dividend, div_by_zero=1. No RUN cycles.
//  - quotient/remainder update only on the done cycle. Intermediate values are never visible on the outputs.
//  - Dividend < divisor gives quotient=0, remainder=dividend. Dividend==0 gives 0/0 results, div_by_zero=0.
// CONFIGURATION
//  - Macro SIGNED_DIV_EN.
//  - Defined: operands are two's complement.
//    - Magnitudes are divided by the unsigned core.
//    - Quotient is negated iff the operand signs differ (truncation toward zero).
//    - Remainder takes the dividend's sign.
//    - Sign fix-up happens in the DONE transition, so latency is unchanged.
//    - Overflow case 0x8000 / 0xFFFF gives quotient=0x8000, remainder=0 (wraps, no extra flag).
//    - Signed divide-by-zero: quotient=all ones, remainder=dividend.
//  - Undefined: purely unsigned, as above; no sign logic is synthesised.
// TESTING
//  - 100/7 (0x0064/0x0007): start for 1 cycle -> busy for 16 cycles, then done with q=0x000E, r=0x0002, dbz=0.
//  - 0xFFFF/0x0001 -> q=0xFFFF, r=0; 0x1234/0x8001 -> q=0, r=0x1234; 0xFFFF/0x8000 -> q=1, r=0x7FFF.
//  - 0x00AB/0x0000 -> done one cycle after start, q=0xFFFF, r=0x00AB, dbz=1, busy never high.
//  - Start 50/5, pulse start with 9/3 at busy cycle 4 -> ignored; q=10, r=0.
//    Then start 9/3 in the done cycle -> q=3, r=0, 17 cycles later.
//  - Assert rst at busy cycle 8 -> all outputs 0 immediately, FSM=IDLE.
//    A fresh start of 20/6 afterwards -> q=3, r=2.
//  - SIGNED_DIV_EN: -7/2 -> q=0xFFFD, r=0xFFFF; 7/-2 -> q=0xFFFD, r=1; 0x8000/0xFFFF -> q=0x8000, r=0.

Source files
------------

// File: rtl/seq_restoring_divider_16bit_if.sv
// Start/done handshake and operand/result bundle for seq_restoring_divider_16bit.
// master: the requester (ALU sequencer or bench). slave: the divider.
interface seq_restoring_divider_16bit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider_16bit.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Trial subtraction is R + ~D + 1; its carry-out (no borrow) picks accept vs. restore.
// Optional feature: define SIGNED_DIV_EN for two's-complement operands
// (magnitudes through the unsigned core, sign fix-up on the way into DONE).
module seq_restoring_divider_16bit #(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    seq_restoring_divider_16bit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   r;        // partial remainder, one bit wider than operands
    logic [WIDTH-1:0] q;        // dividend shifts out as quotient shifts in
    logic [WIDTH-1:0] dvs;      // captured divisor (magnitude when signed)
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             dbz;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH+1:0] diff;
    logic             no_borrow;
    logic [WIDTH:0]   r_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             accept;
    logic             unused_r_msb;

`ifdef SIGNED_DIV_EN
    logic neg_q;
    logic neg_r;
`endif

    assign accept       = bus.start && (state != S_RUN);
    // After a restore step R < divisor, so the top bit never feeds the next shift.
    assign unused_r_msb = r[WIDTH];

    // One restoring iteration plus final-result formatting.
    always_comb begin
        r_sh      = {r[WIDTH-1:0], q[WIDTH-1]};
        diff      = {1'b0, r_sh} + {1'b0, ~{1'b0, dvs}} + (WIDTH+2)'(1);
        no_borrow = diff[WIDTH+1];
        r_nxt     = no_borrow ? diff[WIDTH:0] : r_sh;
        q_nxt     = {q[WIDTH-2:0], no_borrow};
`ifdef SIGNED_DIV_EN
        res_q = neg_q ? (WIDTH'(0) - q_nxt) : q_nxt;
        res_r = neg_r ? (WIDTH'(0) - r_nxt[WIDTH-1:0]) : r_nxt[WIDTH-1:0];
        a_mag = bus.dividend[WIDTH-1] ? (WIDTH'(0) - bus.dividend) : bus.dividend;
        b_mag = bus.divisor[WIDTH-1]  ? (WIDTH'(0) - bus.divisor)  : bus.divisor;
`else
        res_q = q_nxt;
        res_r = r_nxt[WIDTH-1:0];
        a_mag = bus.dividend;
        b_mag = bus.divisor;
`endif
    end

    // FSM, datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            r     <= '0;
            q     <= '0;
            dvs   <= '0;
            quo   <= '0;
            rem   <= '0;
            dbz   <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q <= 1'b0;
            neg_r <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        dbz <= 1'b0;
                        if (bus.divisor == '0) begin
                            quo   <= '1;
                            rem   <= bus.dividend;
                            dbz   <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            r     <= '0;
                            q     <= a_mag;
                            dvs   <= b_mag;
                            cnt   <= '0;
                            state <= S_RUN;
`ifdef SIGNED_DIV_EN
                            neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                            neg_r <= bus.dividend[WIDTH-1];
`endif
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r   <= r_nxt;
                    q   <= q_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH-1)) begin
                        quo   <= res_q;
                        rem   <= res_r;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = (state == S_RUN);
    assign bus.done        = (state == S_DONE);
    assign bus.quotient    = quo;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_seq_restoring_divider_16bit.sv
// Directed bench for seq_restoring_divider_16bit with a result scoreboard.
module tb_seq_restoring_divider_16bit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_restoring_divider_16bit_if #(.WIDTH(16)) bus ();

    seq_restoring_divider_16bit #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   failed = 0;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int sa;
        int sd;
        if (b == 16'h0000) begin
            e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1;
        end else begin
`ifdef SIGNED_DIV_EN
            sa = int'($signed(a));
            sd = int'($signed(b));
            e.q = 16'(sa / sd);
            e.r = 16'(sa % sd);
`else
            sa = int'(a);
            sd = int'(b);
            e.q = 16'(sa / sd);
            e.r = 16'(sa % sd);
`endif
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the following posedge samples start.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input bit push);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        if (push) sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts cycles (negedges) until done, bounded.
    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (bus.busy) bcnt++;
            if (bus.done) break;
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        check({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_q"},   32'(bus.quotient),    32'(e.q));
            check({tag, "_r"},   32'(bus.remainder),   32'(e.r));
            check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(e.dbz));
        end
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input int exp_lat, input int exp_busy);
        int cyc;
        int bcnt;
        launch(a, b, 1'b1);
        wait_done(cyc, bcnt);
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_lat"},  32'(cyc),  32'(exp_lat));
        check({tag, "_busy"}, 32'(bcnt), 32'(exp_busy));
        check_result(tag);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int cyc;
        int bcnt;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy),        32'd0);
        check("rst_done", 32'(bus.done),        32'd0);
        check("rst_q",    32'(bus.quotient),    32'd0);
        check("rst_r",    32'(bus.remainder),   32'd0);
        check("rst_dbz",  32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op("d100_7",   16'h0064, 16'h0007, 17, 16);
        check("d100_7_q_const", 32'(bus.quotient), 32'h000E);
        do_op("ffff_1",   16'hFFFF, 16'h0001, 17, 16);
        do_op("lt",       16'h1234, 16'h8001, 17, 16);
        do_op("bigdiv",   16'hFFFF, 16'h8000, 17, 16);
        do_op("dbz",      16'h00AB, 16'h0000, 1, 0);
        do_op("zero",     16'h0000, 16'h0005, 17, 16);
`ifdef SIGNED_DIV_EN
        do_op("s_m7_2",   16'hFFF9, 16'h0002, 17, 16);
        do_op("s_7_m2",   16'h0007, 16'hFFFE, 17, 16);
        do_op("s_ovf",    16'h8000, 16'hFFFF, 17, 16);
`endif

        // Start pulsed mid-run must be ignored.
        launch(16'd50, 16'd5, 1'b1);
        repeat (4) @(negedge clk);
        check("ign_busy", 32'(bus.busy), 32'd1);
        bus.start    = 1'b1;
        bus.dividend = 16'd9;
        bus.divisor  = 16'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(cyc, bcnt);
        check("ign_lat", 32'(cyc), 32'd13);
        check_result("ign");

        // Back-to-back: start accepted in the done cycle.
        launch(16'd9, 16'd3, 1'b1);
        wait_done(cyc, bcnt);
        check("b2b_lat",  32'(cyc),  32'd17);
        check("b2b_busy", 32'(bcnt), 32'd16);
        check_result("b2b");
        @(negedge clk);

        // Asynchronous reset mid-run.
        launch(16'd1000, 16'd3, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_busy", 32'(bus.busy),        32'd0);
        check("mrst_done", 32'(bus.done),        32'd0);
        check("mrst_q",    32'(bus.quotient),    32'd0);
        check("mrst_r",    32'(bus.remainder),   32'd0);
        check("mrst_dbz",  32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_idle", 32'(bus.busy | bus.done), 32'd0);
        do_op("d20_6", 16'd20, 16'd6, 17, 16);
        check("d20_6_r_const", 32'(bus.remainder), 32'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
